// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the RV32I memory-access (MEM) stage: control-word bit
// positions, load/store funct3 encodings, the bubble instruction and the
// stage FSM state type.
// -----------------------------------------------------------------------------
package mem_pkg;

    // Bit positions inside the 8-bit control word carried down the pipeline.
    localparam int CTRL_RESULTSRC = 0;
    localparam int CTRL_REGWRITE  = 1;
    localparam int CTRL_MEMWRITE  = 2;
    localparam int CTRL_MEMREAD   = 3;

    // funct3 encodings of the RV32I load/store family.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // addi x0, x0, 0 -- what writeback sees for a bubble.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

endpackage

// File: rtl/load_store_align.sv
// -----------------------------------------------------------------------------
// load_store_align
// Purely combinational lane logic for byte/half/word memory accesses.
//   funct3      in  3   access size/signedness
//   addr_lo     in  2   byte offset within the word
//   is_store    in  1   1 = store, 0 = load (selects the legal funct3 set)
//   store_data  in  32  rs2 value
//   rdata       in  32  word returned by the data memory
//   wdata       out 32  store data replicated onto every lane
//   be          out 4   byte enables for the store
//   load_data   out 32  selected lane, sign/zero extended
//   illegal     out 1   unsupported funct3 or misaligned address
// -----------------------------------------------------------------------------
module load_store_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic        is_store,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] load_data,
    output logic        illegal
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Lane selection is independent of funct3, so it stays outside the case.
    assign lane_b = rdata[8*addr_lo +: 8];
    assign lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // NOTE: every output gets a default before the case so no path through
    // the block leaves a signal unassigned, which would infer a latch.
    always_comb begin
        wdata     = store_data;
        be        = 4'b0000;
        load_data = 32'h0;
        illegal   = 1'b0;
        case (funct3)
            F3_B: begin
                wdata     = {4{store_data[7:0]}};
                be        = 4'b0001 << addr_lo;
                load_data = {{24{lane_b[7]}}, lane_b};
            end
            F3_H: begin
                wdata     = {2{store_data[15:0]}};
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                load_data = {{16{lane_h[15]}}, lane_h};
                illegal   = addr_lo[0];
            end
            F3_W: begin
                be        = 4'b1111;
                load_data = rdata;
                illegal   = (addr_lo != 2'b00);
            end
            F3_BU: begin
                load_data = {24'h0, lane_b};
                illegal   = is_store;
            end
            F3_HU: begin
                load_data = {16'h0, lane_h};
                illegal   = is_store | addr_lo[0];
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// -----------------------------------------------------------------------------
// memory_access_stage
// MEM stage of the 5-stage RV32I pipeline. Memory operations are checked for
// legality, latched into hold registers and issued to a variable-latency data
// memory over a req/ack handshake; upstream is stalled while the access is
// outstanding. Results (or bubbles) are registered for writeback.
//   clk1 / rst                       clock, async active-high reset
//   in_valid, ALUResult_in,
//   WriteData_in, Instr_in, ctrl_in  EX-stage outputs
//   stall_out                        upstream must hold its outputs
//   mem_req/we/addr/wdata/be         data-memory request (stable in ACCESS)
//   mem_rdata, mem_ack               data-memory response
//   ALUResult, ReadData,
//   RD_Instr, contrl_sig             registered writeback bundle
//   mem_err                          one-cycle pulse: illegal access / timeout
// -----------------------------------------------------------------------------
module memory_access_stage
    import mem_pkg::*;
#(
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] NOP_WORD  = NOP_INSTR
)(
    input  logic        clk1,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] ALUResult_in,
    input  logic [31:0] WriteData_in,
    input  logic [31:0] Instr_in,
    input  logic [7:0]  ctrl_in,
    output logic        stall_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] ALUResult,
    output logic [31:0] ReadData,
    output logic [31:0] RD_Instr,
    output logic [7:0]  contrl_sig,
    output logic        mem_err
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t state, state_next;

    // Hold registers for the access in flight.
    logic [31:0]      addr_q;
    logic [31:0]      data_q;
    logic [31:0]      instr_q;
    logic [7:0]       ctrl_q;
    logic [CNT_W-1:0] cnt_q;

    logic in_mem_op;
    logic in_is_store;
    logic held_is_store;
    logic timed_out;

    // Shared lane logic: looks at the incoming instruction while IDLE (for the
    // legality check) and at the hold registers while ACCESS.
    logic [2:0]  sel_funct3;
    logic [1:0]  sel_addr_lo;
    logic        sel_is_store;
    logic [31:0] lsa_wdata;
    logic [3:0]  lsa_be;
    logic [31:0] lsa_load;
    logic        lsa_illegal;

    // A store wins when both MemRead and MemWrite are set.
    assign in_mem_op     = ctrl_in[CTRL_MEMREAD] | ctrl_in[CTRL_MEMWRITE];
    assign in_is_store   = ctrl_in[CTRL_MEMWRITE];
    assign held_is_store = ctrl_q[CTRL_MEMWRITE];
    assign timed_out     = (cnt_q == CNT_LAST);

    assign sel_funct3   = (state == ACCESS) ? instr_q[14:12] : Instr_in[14:12];
    assign sel_addr_lo  = (state == ACCESS) ? addr_q[1:0]    : ALUResult_in[1:0];
    assign sel_is_store = (state == ACCESS) ? held_is_store  : in_is_store;

    load_store_align u_align (
        .funct3     (sel_funct3),
        .addr_lo    (sel_addr_lo),
        .is_store   (sel_is_store),
        .store_data (data_q),
        .rdata      (mem_rdata),
        .wdata      (lsa_wdata),
        .be         (lsa_be),
        .load_data  (lsa_load),
        .illegal    (lsa_illegal)
    );

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (in_valid && in_mem_op && !lsa_illegal) state_next = ACCESS;
            ACCESS: if (mem_ack || timed_out)                  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Derived from state and hold registers only, so the request is stable
    // for the whole access and drops the instant reset is asserted.
    always_comb begin
        stall_out = (state == ACCESS);
        mem_req   = (state == ACCESS);
        mem_we    = (state == ACCESS) && held_is_store;
        mem_be    = (state == ACCESS) ? lsa_be    : 4'b0000;
        mem_wdata = (state == ACCESS) ? lsa_wdata : 32'h0;
    end

    assign mem_addr = {addr_q[31:2], 2'b00};

    // ---------------- Datapath / writeback registers ----------------
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            // Hold registers are reset too: they drive mem_addr directly.
            addr_q     <= 32'h0;
            data_q     <= 32'h0;
            instr_q    <= NOP_WORD;
            ctrl_q     <= 8'h0;
            cnt_q      <= '0;
            ALUResult  <= 32'h0;
            ReadData   <= 32'h0;
            RD_Instr   <= NOP_WORD;
            contrl_sig <= 8'h0;
            mem_err    <= 1'b0;
        end else begin
            // Default every edge to a bubble; the cases below override it.
            ALUResult  <= 32'h0;
            ReadData   <= 32'h0;
            RD_Instr   <= NOP_WORD;
            contrl_sig <= 8'h0;
            mem_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (!in_mem_op) begin
                            ALUResult  <= ALUResult_in;
                            RD_Instr   <= Instr_in;
                            contrl_sig <= ctrl_in;
                        end else if (lsa_illegal) begin
                            mem_err <= 1'b1;
                        end else begin
                            addr_q  <= ALUResult_in;
                            data_q  <= WriteData_in;
                            instr_q <= Instr_in;
                            ctrl_q  <= ctrl_in;
                            cnt_q   <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        ALUResult  <= addr_q;
                        ReadData   <= held_is_store ? 32'h0 : lsa_load;
                        RD_Instr   <= instr_q;
                        contrl_sig <= ctrl_q;
                    end else if (timed_out) begin
                        mem_err <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_access_stage
// Directed steps followed by random transactions against a byte-lane model of
// RV32I load/store semantics.
// -----------------------------------------------------------------------------
module tb_memory_access_stage;

    localparam int          TIMEOUT = 16;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam int          NO_ACK  = 1000;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] ALUResult_in;
    logic [31:0] WriteData_in;
    logic [31:0] Instr_in;
    logic [7:0]  ctrl_in;
    logic        stall_out;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] ALUResult;
    logic [31:0] ReadData;
    logic [31:0] RD_Instr;
    logic [7:0]  contrl_sig;
    logic        mem_err;

    int n_compared   = 0;
    int n_mismatched = 0;

    memory_access_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk1         (clk1),
        .rst          (rst),
        .in_valid     (in_valid),
        .ALUResult_in (ALUResult_in),
        .WriteData_in (WriteData_in),
        .Instr_in     (Instr_in),
        .ctrl_in      (ctrl_in),
        .stall_out    (stall_out),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .ALUResult    (ALUResult),
        .ReadData     (ReadData),
        .RD_Instr     (RD_Instr),
        .contrl_sig   (contrl_sig),
        .mem_err      (mem_err)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int access_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit model_legal(input logic [2:0] f3, input bit is_store, input logic [1:0] off);
        bit ok;
        if (is_store) ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        else          ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        return ok && ((int'(off) % access_size(f3)) == 0);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] data);
        logic [31:0] w = 0;
        int sz = access_size(f3);
        for (int i = 0; i < 4; i++)
            w = w | (((data >> (8 * (i % sz))) & 32'hFF) << (8 * i));
        return w;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] b = 0;
        int sz = access_size(f3);
        for (int i = 0; i < 4; i++)
            b[i] = (i >= int'(off)) && (i < int'(off) + sz);
        return b;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rdata);
        int sz = access_size(f3);
        logic [31:0] v = rdata >> (8 * int'(off));
        logic [31:0] mask;
        if (sz == 4) return v;
        mask = (32'h1 << (8 * sz)) - 1;
        v = v & mask;
        if (!f3[2] && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- transaction driver ----------------
    // Drives one EX-stage instruction at a negedge and walks it through the
    // stage, checking every observable effect at the following negedges.
    // ack_delay = number of ACCESS cycles before the ack cycle (NO_ACK: none).
    task automatic run_op(input string tag, input logic [7:0] ctrl, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] data,
                          input int ack_delay, input logic [31:0] rdata);
        logic [31:0] instr;
        bit          mem_op, is_store;
        int          cyc;
        bit          done;
        instr        = $urandom;
        instr[14:12] = f3;
        mem_op       = ctrl[3] | ctrl[2];
        is_store     = ctrl[2];
        in_valid     = 1'b1;
        ALUResult_in = addr;
        WriteData_in = data;
        Instr_in     = instr;
        ctrl_in      = ctrl;
        mem_ack      = 1'b0;
        @(negedge clk1);
        in_valid     = 1'b0;
        // Scramble the inputs: the stage must work from its hold registers.
        ALUResult_in = $urandom;
        WriteData_in = $urandom;
        Instr_in     = $urandom;
        ctrl_in      = 8'($urandom);
        if (!mem_op) begin
            check({tag, " alu"},    ALUResult,  addr);
            check({tag, " rdata"},  ReadData,   32'h0);
            check({tag, " instr"},  RD_Instr,   instr);
            check({tag, " ctrl"},   contrl_sig, 32'(ctrl));
            check({tag, " stall"},  stall_out,  32'h0);
            check({tag, " err"},    mem_err,    32'h0);
        end else if (!model_legal(f3, is_store, addr[1:0])) begin
            check({tag, " err"},    mem_err,    32'h1);
            check({tag, " req"},    mem_req,    32'h0);
            check({tag, " stall"},  stall_out,  32'h0);
            check({tag, " instr"},  RD_Instr,   NOP);
            check({tag, " ctrl"},   contrl_sig, 32'h0);
        end else begin
            done = 0;
            cyc  = 0;
            while (!done) begin
                check({tag, " stall"},  stall_out, 32'h1);
                check({tag, " req"},    mem_req,   32'h1);
                check({tag, " we"},     mem_we,    32'(is_store));
                check({tag, " addr"},   mem_addr,  {addr[31:2], 2'b00});
                check({tag, " wbnop"},  RD_Instr,  NOP);
                if (is_store) begin
                    check({tag, " be"},    mem_be,    32'(model_be(f3, addr[1:0])));
                    check({tag, " wdata"}, mem_wdata, model_wdata(f3, data));
                end
                if (cyc == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end else begin
                    mem_rdata = $urandom;
                end
                @(negedge clk1);
                mem_ack = 1'b0;
                if (cyc == ack_delay) begin
                    done = 1;
                    check({tag, " alu"},   ALUResult,  addr);
                    check({tag, " rdata"}, ReadData,   is_store ? 32'h0 : model_load(f3, addr[1:0], rdata));
                    check({tag, " instr"}, RD_Instr,   instr);
                    check({tag, " ctrl"},  contrl_sig, 32'(ctrl));
                    check({tag, " err"},   mem_err,    32'h0);
                    check({tag, " stall"}, stall_out,  32'h0);
                end else if (cyc == TIMEOUT - 1) begin
                    done = 1;
                    check({tag, " tmo_err"},   mem_err,   32'h1);
                    check({tag, " tmo_stall"}, stall_out, 32'h0);
                    check({tag, " tmo_instr"}, RD_Instr,  NOP);
                end else begin
                    check({tag, " err_mid"}, mem_err, 32'h0);
                end
                cyc++;
                if (cyc > TIMEOUT + 2) begin
                    check({tag, " bound"}, 32'(cyc), 32'(TIMEOUT));
                    done = 1;
                end
            end
        end
    endtask

    // One bubble cycle; a stray ack in IDLE must be ignored.
    task automatic idle_cycle(input string tag);
        in_valid  = 1'b0;
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        @(negedge clk1);
        mem_ack = 1'b0;
        check({tag, " idle instr"}, RD_Instr,   NOP);
        check({tag, " idle ctrl"},  contrl_sig, 32'h0);
        check({tag, " idle alu"},   ALUResult,  32'h0);
        check({tag, " idle rd"},    ReadData,   32'h0);
        check({tag, " idle err"},   mem_err,    32'h0);
        check({tag, " idle stall"}, stall_out,  32'h0);
        check({tag, " idle req"},   mem_req,    32'h0);
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        ALUResult_in = 32'h0;
        WriteData_in = 32'h0;
        Instr_in     = 32'h0;
        ctrl_in      = 8'h0;
        mem_rdata    = 32'h0;
        mem_ack      = 1'b0;
        #1;
        check("reset instr", RD_Instr,   NOP);
        check("reset ctrl",  contrl_sig, 32'h0);
        check("reset alu",   ALUResult,  32'h0);
        check("reset rdata", ReadData,   32'h0);
        check("reset req",   mem_req,    32'h0);
        check("reset be",    mem_be,     32'h0);
        check("reset stall", stall_out,  32'h0);
        check("reset err",   mem_err,    32'h0);
        @(negedge clk1);
        rst = 1'b0;
        @(negedge clk1);

        // Directed steps.
        run_op("add",  8'h02, 3'd0, 32'h0000_0005, 32'h0, 0, 32'h0);
        idle_cycle("add");
        run_op("lb",   8'h0B, 3'd0, 32'h0000_0103, 32'h0, 2, 32'h80FF_FF00);
        check("lb value", ReadData, 32'hFFFF_FF80);
        idle_cycle("lb");
        run_op("lhu",  8'h0B, 3'd5, 32'h0000_0102, 32'h0, 0, 32'h8001_0000);
        check("lhu value", ReadData, 32'h0000_8001);
        run_op("sb",   8'h04, 3'd0, 32'h0000_0201, 32'h1234_56AB, 1, 32'hDEAD_BEEF);
        run_op("lwmis", 8'h0B, 3'd2, 32'h0000_0302, 32'h0, 0, 32'h0);
        idle_cycle("lwmis");
        run_op("swtmo", 8'h04, 3'd2, 32'h0000_0400, 32'hCAFE_F00D, NO_ACK, 32'h0);
        idle_cycle("swtmo");
        run_op("shboth", 8'h0E, 3'd1, 32'h0000_0502, 32'h0000_BEEF, 3, 32'h1111_2222);
        run_op("sbu_ill", 8'h04, 3'd4, 32'h0000_0600, 32'h0, 0, 32'h0);
        run_op("lh_ack_last", 8'h0B, 3'd1, 32'h0000_0700, 32'h0, TIMEOUT - 1, 32'h0000_8000);
        check("lh_ack_last value", ReadData, 32'hFFFF_8000);

        // Reset in the middle of an access.
        in_valid     = 1'b1;
        ctrl_in      = 8'h0B;
        Instr_in     = 32'h0000_2003;
        ALUResult_in = 32'h0000_0800;
        @(negedge clk1);
        in_valid = 1'b0;
        @(negedge clk1);
        check("mid req before rst", mem_req, 32'h1);
        rst = 1'b1;
        #1;
        check("mid rst req",   mem_req,   32'h0);
        check("mid rst instr", RD_Instr,  NOP);
        check("mid rst stall", stall_out, 32'h0);
        #2;
        rst = 1'b0;
        @(negedge clk1);
        run_op("lw_after_rst", 8'h0B, 3'd2, 32'h0000_0900, 32'h0, 1, 32'h1357_9BDF);

        // Random transactions.
        for (int n = 0; n < 150; n++) begin
            logic [7:0]  ctrl;
            logic [2:0]  f3;
            int          delay;
            ctrl = 8'($urandom);
            case ($urandom_range(0, 3))
                0: ctrl[3:2] = 2'b00;
                1: ctrl[3:2] = 2'b10;
                2: ctrl[3:2] = 2'b01;
                default: ctrl[3:2] = 2'b11;
            endcase
            f3    = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            delay = ($urandom_range(0, 9) == 0) ? NO_ACK : $urandom_range(0, 5);
            run_op("rnd", ctrl, f3, $urandom, $urandom, delay, $urandom);
            if ($urandom_range(0, 2) == 0) idle_cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    // Global time limit so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
